// File: rtl/ext_access_filter_if.sv
// ext_access_filter_if: request/response and controller-side signals of the access filter.
// Ports: req_* (queued requests), rsp_* (held responses), ext_* / access_level (controller port).
// Modports: slave = filter view, master = requester + controller view.
interface ext_access_filter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_level;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_write_data;
  logic              ext_write_enable;
  logic              ext_read_enable;
  logic [DATA_W-1:0] ext_read_data;
  logic [1:0]        access_level;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_level, rsp_ready, ext_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ext_addr, ext_write_data, ext_write_enable, ext_read_enable, access_level
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_level, rsp_ready, ext_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ext_addr, ext_write_data, ext_write_enable, ext_read_enable, access_level
  );
endinterface

// File: rtl/ext_access_filter.sv
// ext_access_filter: queues external requests, checks region/privilege policy, forwards
//   permitted ones to the controller ext_* port and answers denials with an error response.
// Ports: clk, reset_n (async active-low), bus (slave modport of ext_access_filter_if),
//   viol_count / viol_addr (denial statistics), locked (lockout state).
// Latency pop->rsp_valid: deny 1, write 2, read RD_LAT+2; req_ready = !full, rsp held until rsp_ready.
// Optional feature: ACCESS_FILTER_LOCKOUT_EN enables the lockout state machine around denials.
module ext_access_filter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  ext_access_filter_if.slave  bus,
  output logic [7:0]          viol_count,
  output logic [ADDR_W-1:0]   viol_addr,
  output logic                locked
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + ADDR_W + DATA_W + 2;
  // The wait counter only has to count RD_LAT-2 down to zero.
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_CAPTURE, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic              full, empty, push, pop;
  logic              hd_write;
  logic [ADDR_W-1:0] hd_addr;
  logic [DATA_W-1:0] hd_wdata;
  logic [1:0]        hd_level;
  logic              permit;
  logic              op_write_q;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] ext_addr_q;
  logic [DATA_W-1:0] ext_wdata_q;
  logic [1:0]        access_level_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [7:0]        viol_count_q;
  logic [ADDR_W-1:0] viol_addr_q;
  logic              locked_q;

  // Request queue: extra pointer bit distinguishes full from empty.
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus.req_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign {hd_write, hd_addr, hd_wdata, hd_level} = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {bus.req_write, bus.req_addr, bus.req_wdata, bus.req_level};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Region/privilege policy on the queue head.
  always_comb begin
    permit = 1'b0;
    unique case (hd_addr[ADDR_W-1 -: 2])
      2'd0: permit = 1'b1;
      2'd1: permit = hd_write ? (hd_level >= 2'd2) : (hd_level >= 2'd1);
      2'd2: permit = hd_write ? (hd_level == 2'd3) : (hd_level >= 2'd2);
      2'd3: permit = (hd_level == 2'd3);
    endcase
`ifdef ACCESS_FILTER_LOCKOUT_EN
    if (locked_q && hd_level != 2'd3) permit = 1'b0;
`endif
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      S_IDLE:    if (!empty) state_d = permit ? S_ISSUE : S_RESP;
      S_ISSUE: begin
        // The ISSUE cycle is the first of the RD_LAT read-enable cycles.
        if (op_write_q)       state_d = S_RESP;
        else if (RD_LAT == 1) state_d = S_CAPTURE;
        else begin
          state_d  = S_WAIT_RD;
          rd_cnt_d = CNT_W'(RD_LAT >= 2 ? RD_LAT - 2 : 0);
        end
      end
      S_WAIT_RD: begin
        if (rd_cnt_q == '0) state_d = S_CAPTURE;
        else                rd_cnt_d = rd_cnt_q - 1'b1;
      end
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (bus.rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs decoded straight from the state so async reset drops the enables at once.
  assign bus.ext_write_enable = (state_q == S_ISSUE) && op_write_q;
  assign bus.ext_read_enable  = ((state_q == S_ISSUE) && !op_write_q) || (state_q == S_WAIT_RD);
  assign bus.rsp_valid        = (state_q == S_RESP);

  // Datapath: holding registers, response registers, violation statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_write_q     <= 1'b0;
      ext_addr_q     <= '0;
      ext_wdata_q    <= '0;
      access_level_q <= '0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      viol_count_q   <= '0;
      viol_addr_q    <= '0;
    end else begin
      if (pop) begin
        op_write_q  <= hd_write;
        rsp_rdata_q <= '0;
        rsp_err_q   <= !permit;
        if (permit) begin
          // Controller-facing fields only change for forwarded requests.
          ext_addr_q     <= hd_addr;
          ext_wdata_q    <= hd_wdata;
          access_level_q <= hd_level;
        end else begin
          if (viol_count_q != 8'hFF) viol_count_q <= viol_count_q + 8'd1;
          viol_addr_q <= hd_addr;
        end
      end
      if (state_q == S_CAPTURE) rsp_rdata_q <= bus.ext_read_data;
    end
  end

`ifdef ACCESS_FILTER_LOCKOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           locked_q <= 1'b0;
    else if (pop && !permit) locked_q <= 1'b1;
    else if (bus.ext_write_enable && access_level_q == 2'd3 && (&ext_addr_q))
      locked_q <= 1'b0;
  end
`else
  assign locked_q = 1'b0;
`endif

  assign bus.req_ready      = !full;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.ext_addr       = ext_addr_q;
  assign bus.ext_write_data = ext_wdata_q;
  assign bus.access_level   = access_level_q;
  assign viol_count         = viol_count_q;
  assign viol_addr          = viol_addr_q;
  assign locked             = locked_q;
endmodule
